// File: rtl/fetch_pkg.sv
// Shared widths, default bubble word and next-PC select encoding for the fetch stage.
package fetch_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    // Instruction word written into IF/ID when a bubble is inserted
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // Forces the two low bits of a byte address to zero (word alignment)
    localparam logic [PC_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Next-PC mux select
    typedef enum logic [1:0] {
        SEL_ADV  = 2'd0,
        SEL_HOLD = 2'd1,
        SEL_BR   = 2'd2,
        SEL_JMP  = 2'd3
    } fetch_sel_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: next-PC selection and the PC flop with async active-low reset.
// Also exports PC+4 so the stage shares one incrementer.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  fetch_sel_t       sel,
    input  logic [PC_W-1:0]  br_target,
    input  logic [PC_W-1:0]  jmp_target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4
);

    // Reset PC is always word aligned regardless of the parameter's low bits
    localparam logic [PC_W-1:0] RESET_PC_ALIGNED = RESET_PC & WORD_ALIGN_MASK;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Wraps modulo 2^32 naturally
    assign pc_plus4 = pc_q + 32'd4;
    assign pc       = pc_q;

    // Next-PC mux; redirect targets are forced to word alignment
    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_ADV:  pc_d = pc_plus4;
            SEL_HOLD: pc_d = pc_q;
            SEL_BR:   pc_d = br_target & WORD_ALIGN_MASK;
            SEL_JMP:  pc_d = jmp_target & WORD_ALIGN_MASK;
            default:  pc_d = pc_q;
        endcase
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_ALIGNED;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the fetch address from the PC, captures the
// returned instruction into IF/ID, and resolves stall / branch / jump requests.
// Optional feature macro: FETCH_PERF_EN adds saturating fetch and bubble counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic [PC_W-1:0]   Addr,
    input  logic [INST_W-1:0] Inst,
    input  logic              Stall,
    input  logic              Branch_Taken,
    input  logic [PC_W-1:0]   Branch_Target,
    input  logic              Jump,
    input  logic [PC_W-1:0]   Jump_Target,
    output logic [INST_W-1:0] IF_ID_Inst,
    output logic [PC_W-1:0]   IF_ID_PC4,
    output logic              IF_ID_Valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       Fetch_Count,
    output logic [31:0]       Bubble_Count
`endif
);

    fetch_sel_t        sel;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus4;

    logic [INST_W-1:0] if_id_inst_q, if_id_inst_d;
    logic [PC_W-1:0]   if_id_pc4_q,  if_id_pc4_d;
    logic              if_id_valid_q, if_id_valid_d;

    // One action per edge: jump beats branch, any redirect beats stall
    always_comb begin
        sel = SEL_ADV;
        if (Jump) begin
            sel = SEL_JMP;
        end else if (Branch_Taken) begin
            sel = SEL_BR;
        end else if (Stall) begin
            sel = SEL_HOLD;
        end
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .sel        (sel),
        .br_target  (Branch_Target),
        .jmp_target (Jump_Target),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    // Fetch address is the PC with nothing else on the path
    assign Addr = pc;

    // IF/ID next state: bubble on redirect, hold on stall, capture on advance
    always_comb begin
        if_id_inst_d  = if_id_inst_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        case (sel)
            SEL_BR, SEL_JMP: begin
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
            end
            SEL_ADV: begin
                if_id_inst_d  = Inst;
                if_id_pc4_d   = pc_plus4;
                if_id_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // IF/ID pipeline register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            if_id_inst_q  <= NOP_INST;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign IF_ID_Inst  = if_id_inst_q;
    assign IF_ID_PC4   = if_id_pc4_q;
    assign IF_ID_Valid = if_id_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    // Saturating event counters: advances and redirect bubbles
    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (sel == SEL_ADV && fetch_count_q != 32'hFFFF_FFFF) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if ((sel == SEL_BR || sel == SEL_JMP) && bubble_count_q != 32'hFFFF_FFFF) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign Fetch_Count  = fetch_count_q;
    assign Bubble_Count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules. Honours FETCH_PERF_EN.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0042;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
`ifdef FETCH_PERF_EN
    logic [31:0] Fetch_Count;
    logic [31:0] Bubble_Count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit scramble = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid;
    logic [31:0] m_fetch, m_bub;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Addr          (Addr),
        .Inst          (Inst),
        .Stall         (Stall),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Jump          (Jump),
        .Jump_Target   (Jump_Target),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_PC4     (IF_ID_PC4),
        .IF_ID_Valid   (IF_ID_Valid)
`ifdef FETCH_PERF_EN
        ,
        .Fetch_Count   (Fetch_Count),
        .Bubble_Count  (Bubble_Count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory contents as a function of byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit scr);
        if (scr) return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        return a;
    endfunction

    assign Inst = mem_word(Addr, scramble);

    task automatic model_reset();
        m_pc    = RST_PC & 32'hFFFF_FFFC;
        m_inst  = NOP;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fetch = 32'h0;
        m_bub   = 32'h0;
    endtask

    task automatic clear_inputs();
        Stall = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0;
        Branch_Target = 32'h0; Jump_Target = 32'h0;
    endtask

    // One rising edge; the model applies the fetch rules to the sampled inputs
    task automatic tick();
        @(posedge Clk);
        if (Jump || Branch_Taken) begin
            m_pc    = (Jump ? Jump_Target : Branch_Target) & 32'hFFFF_FFFC;
            m_inst  = NOP;
            m_valid = 1'b0;
            if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
        end else if (!Stall) begin
            m_inst  = mem_word(m_pc, scramble);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h40, NOP, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%h inst=%h pc4=%h v=%b, want addr=40 inst=%h pc4=0 v=0",
                     Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, NOP);
        end
        Rst_n = 1'b1;
        $display("reset: addr=%h inst=%h pc4=%h v=%b", Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
    endtask

    task automatic test_advance();
        tick();
        n_checks++;
        if ({IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h40, 32'h44, 1'b1}) begin
            n_fail++;
            $display("FAIL first_fetch: got inst=%h pc4=%h v=%b, want inst=40 pc4=44 v=1",
                     IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
        end
        tick(); tick();
        n_checks++;
        if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h4C, 32'h48, 32'h4C, 1'b1}) begin
            n_fail++;
            $display("FAIL advance_3: got addr=%h inst=%h pc4=%h v=%b, want addr=4c inst=48 pc4=4c v=1",
                     Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
        end
        $display("advance: addr=%h inst=%h pc4=%h v=%b", Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
    endtask

    task automatic test_stall();
        // Redirect to 0xC then advance once so PC sits at 0x10 with a valid IF/ID
        Jump = 1'b1; Jump_Target = 32'hC;
        tick();
        Jump = 1'b0;
        tick();
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h10, 32'hC, 32'h10, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got addr=%h inst=%h pc4=%h v=%b, want addr=10 inst=c pc4=10 v=1",
                         i, Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
            end
        end
        Stall = 1'b0;
        tick();
        n_checks++;
        if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h14, 32'h10, 32'h14, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_release: got addr=%h inst=%h pc4=%h v=%b, want addr=14 inst=10 pc4=14 v=1",
                     Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
        end
        $display("stall: addr=%h inst=%h pc4=%h v=%b", Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
    endtask

    task automatic test_branch_over_stall();
        Branch_Taken = 1'b1; Branch_Target = 32'h83; Stall = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h80, NOP, 32'h14, 1'b0}) begin
            n_fail++;
            $display("FAIL branch_bubble: got addr=%h inst=%h pc4=%h v=%b, want addr=80 inst=%h pc4=14 v=0",
                     Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, NOP);
        end
        tick();
        n_checks++;
        if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h84, 32'h80, 32'h84, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_target_fetch: got addr=%h inst=%h pc4=%h v=%b, want addr=84 inst=80 pc4=84 v=1",
                     Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
        end
        $display("branch: addr=%h inst=%h pc4=%h v=%b", Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
    endtask

    task automatic test_jump_priority();
        Jump = 1'b1; Jump_Target = 32'h200;
        Branch_Taken = 1'b1; Branch_Target = 32'h100;
        tick();
        clear_inputs();
        n_checks++;
        if ({Addr, IF_ID_Valid} !== {32'h200, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_priority: got addr=%h v=%b, want addr=200 v=0", Addr, IF_ID_Valid);
        end
        $display("jump_priority: addr=%h v=%b", Addr, IF_ID_Valid);
    endtask

    task automatic test_wrap_and_async_reset();
        Jump = 1'b1; Jump_Target = 32'hFFFF_FFFE;
        tick();
        clear_inputs();
        n_checks++;
        if (Addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL jump_align: got addr=%h, want fffffffc", Addr);
        end
        tick();
        n_checks++;
        if ({Addr, IF_ID_PC4, IF_ID_Valid} !== {32'h0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL pc_wrap: got addr=%h pc4=%h v=%b, want addr=0 pc4=0 v=1",
                     Addr, IF_ID_PC4, IF_ID_Valid);
        end
        // Pulse reset between edges with a redirect pending
        Jump = 1'b1; Jump_Target = 32'h300;
        #1;
        Rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {32'h40, NOP, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%h inst=%h pc4=%h v=%b, want addr=40 inst=%h pc4=0 v=0",
                     Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, NOP);
        end
        #1;
        Rst_n = 1'b1;
        clear_inputs();
`ifdef FETCH_PERF_EN
        n_checks++;
        if ({Fetch_Count, Bubble_Count} !== 64'h0) begin
            n_fail++;
            $display("FAIL perf_reset: got fetch=%0d bubble=%0d, want 0 0", Fetch_Count, Bubble_Count);
        end
`endif
        $display("wrap_reset: addr=%h inst=%h pc4=%h v=%b", Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
    endtask

    task automatic test_random();
        scramble = 1'b1;
        for (int i = 0; i < 400; i++) begin
            Stall         = ($urandom_range(0, 99) < 30);
            Branch_Taken  = ($urandom_range(0, 99) < 12);
            Jump          = ($urandom_range(0, 99) < 8);
            Branch_Target = $urandom;
            Jump_Target   = $urandom;
            tick();
            n_checks++;
            if ({Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid} !== {m_pc, m_inst, m_pc4, m_valid}) begin
                n_fail++;
                $display("FAIL random[%0d]: got addr=%h inst=%h pc4=%h v=%b, want addr=%h inst=%h pc4=%h v=%b",
                         i, Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, m_pc, m_inst, m_pc4, m_valid);
            end
`ifdef FETCH_PERF_EN
            n_checks++;
            if ({Fetch_Count, Bubble_Count} !== {m_fetch, m_bub}) begin
                n_fail++;
                $display("FAIL random_perf[%0d]: got fetch=%0d bubble=%0d, want fetch=%0d bubble=%0d",
                         i, Fetch_Count, Bubble_Count, m_fetch, m_bub);
            end
`endif
            if (i % 50 == 0)
                $display("random[%0d]: addr=%h inst=%h pc4=%h v=%b", i, Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_advance();
        test_stall();
        test_branch_over_stall();
        test_jump_priority();
        test_wrap_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
